// File: rtl/parity_check_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | parity_check_receiver: even-parity checker feeding a DEPTH-entry FIFO with   |
// | per-word error flag, sticky alarm and saturating error count.               |
// | Optional: PARITY_ERR_DROP_EN discards erroneous words instead of buffering. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module parity_check_receiver #(
  parameter int WORD_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_parity,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  alarm,
  input  logic                  alarm_clr,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int                   c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]        c_FULL    = (c_AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  logic [WORD_WIDTH-1:0] r_mem_data [DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW:0]         r_count;
  logic                  r_alarm;
  logic [CNT_WIDTH-1:0]  r_err_count;

  logic w_push;
  logic w_pop;
  logic w_err;
  logic w_write;

  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_err     = (^in_data) ^ in_parity;
  assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign alarm     = r_alarm;
  assign err_count = r_err_count;

`ifdef PARITY_ERR_DROP_EN
  // Erroneous words complete the handshake but never occupy a slot.
  assign w_write = w_push & ~w_err;
  assign out_err = 1'b0;
`else
  logic r_mem_err [DEPTH];

  assign w_write = w_push;
  assign out_err = out_valid ? r_mem_err[r_rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_err[r_wr_ptr] <= w_err;
    end
  end
`endif

  // Storage is deliberately not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_data[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as a clear wins: the count restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm     <= 1'b0;
      r_err_count <= '0;
    end else if (w_push && w_err) begin
      r_alarm <= 1'b1;
      if (alarm_clr) begin
        r_err_count <= c_CNT_ONE;
      end else if (!(&r_err_count)) begin
        r_err_count <= r_err_count + c_CNT_ONE;
      end
    end else if (alarm_clr) begin
      r_alarm     <= 1'b0;
      r_err_count <= '0;
    end
  end

endmodule
`default_nettype wire
